// File: rtl/serial_link_scheduler.sv
// Two-requester round-robin scheduler driving one serial frame link.
// A granted payload is shifted out MSB first on sdata, framed by cs_n and
// clocked by sclk, which is divided down from clk.
module serial_link_scheduler #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             sclk,
  output logic             sdata,
  output logic             cs_n
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // A zero-width divider is not legal, so DIV_BITS=0 uses one bit pinned at 0.
  localparam int unsigned CW = (DIV_BITS > 0) ? DIV_BITS : 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] DivMax = (DIV_BITS > 0) ? {CW{1'b1}} : '0;
  localparam logic [BW-1:0] BitMax = BW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ptr_q, ptr_d;      // requester that wins a tie
  logic             owner_q, owner_d;  // requester owning the current frame
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d, sclk_q, sclk_d, sdata_q, sdata_d, cs_n_q, cs_n_d;
  logic             win;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    cs_n_d  = cs_n_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    win     = (req0 && req1) ? ptr_q : req1;

    unique case (state_q)
      StIdle: begin
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        cs_n_d  = 1'b1;
        if (req0 || req1) begin
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          shreg_d = win ? data1 : data0;
          sdata_d = win ? data1[WIDTH-1] : data0[WIDTH-1];
          cs_n_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_q == DivMax) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            bit_d = bit_q + 1'b1;
          end else if (bit_q < BitMax) begin
            // Falling sclk edge: present the next bit well before the next rise.
            shreg_d = shreg_q << 1;
            sdata_d = shreg_q[WIDTH-2];
          end else begin
            cs_n_d  = 1'b1;
            sdata_d = 1'b0;
            done0_d = ~owner_q;
            done1_d = owner_q;
            ptr_d   = ~owner_q;
            state_d = StDone;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_serial_link_scheduler.sv
// Directed bench for serial_link_scheduler: default instance (8-bit, /4 divider)
// plus a 4-bit, undivided instance for the divider corner.
module tb_serial_link_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, done0, done1, busy, sclk, sdata, cs_n;

  logic       dreq0 = 1'b0, dreq1 = 1'b0;
  logic [3:0] ddata0 = '0, ddata1 = '0;
  logic       dgnt0, dgnt1, ddone0, ddone1, dbusy, dsclk, dsdata, dcs_n;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_link_scheduler #(.WIDTH(8), .DIV_BITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .sclk(sclk), .sdata(sdata), .cs_n(cs_n)
  );

  serial_link_scheduler #(.WIDTH(4), .DIV_BITS(0)) u_div (
    .clk(clk), .rst_n(rst_n), .req0(dreq0), .req1(dreq1), .data0(ddata0), .data1(ddata1),
    .gnt0(dgnt0), .gnt1(dgnt1), .done0(ddone0), .done1(ddone1), .busy(dbusy),
    .sclk(dsclk), .sdata(dsdata), .cs_n(dcs_n)
  );

  // Waits for a grant, then follows the frame to its done pulse, collecting
  // rising-sclk samples, cycle stamps and any exclusivity/pre-emption violations.
  task automatic wait_frame(input bit drop, output int owner, output int g_cyc,
                            output int d_cyc, output int d_owner, output logic [7:0] bits,
                            output int rises, output int csn_low, output int excl);
    logic prev;
    owner = -1; d_owner = -1; bits = '0; rises = 0; csn_low = 0; excl = 0;
    g_cyc = 0; d_cyc = 0;
    for (int i = 0; i < 20 && owner < 0; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) excl++;
      if (gnt0) owner = 0;
      else if (gnt1) owner = 1;
    end
    if (owner >= 0) begin
      g_cyc = cyc;
      if (!cs_n) csn_low++;
      if (drop) begin
        if (owner == 0) req0 = 1'b0;
        else req1 = 1'b0;
      end
      prev = sclk;
      for (int i = 0; i < 200 && d_owner < 0; i++) begin
        @(negedge clk);
        if (gnt0 || gnt1) excl++;
        if (done0 && done1) excl++;
        if (sclk && !prev) begin
          bits = {bits[6:0], sdata};
          rises++;
        end
        prev = sclk;
        if (done0) d_owner = 0;
        else if (done1) d_owner = 1;
        else if (!cs_n) csn_low++;
      end
      d_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else passed++;
    checks++; if ({sclk, sdata} !== 2'b00) $display("FAIL reset_sclk_sdata: got %b want 00", {sclk, sdata}); else passed++;
    checks++; if ({gnt0, gnt1, done0, done1, busy} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000", {gnt0, gnt1, done0, done1, busy}); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, cs_n} !== 2'b01) $display("FAIL idle_after_reset: got %b want 01", {busy, cs_n}); else passed++;
  endtask

  task automatic test_contention();
    int o1, g1, d1, do1, r1, c1, e1, o2, g2, d2, do2, r2, c2, e2;
    logic [7:0] b1, b2;
    data0 = 8'h3C; data1 = 8'hC3; req0 = 1'b1; req1 = 1'b1;
    wait_frame(1'b1, o1, g1, d1, do1, b1, r1, c1, e1);
    wait_frame(1'b1, o2, g2, d2, do2, b2, r2, c2, e2);
    checks++; if (o1 !== 0) $display("FAIL contention_first: got %0d want 0", o1); else passed++;
    checks++; if (b1 !== 8'h3C) $display("FAIL contention_bits0: got %h want 3c", b1); else passed++;
    checks++; if (o2 !== 1) $display("FAIL contention_second: got %0d want 1", o2); else passed++;
    checks++; if (b2 !== 8'hC3) $display("FAIL contention_bits1: got %h want c3", b2); else passed++;
    checks++; if (g2 - d1 !== 2) $display("FAIL contention_gap: got %0d want 2", g2 - d1); else passed++;
    checks++; if (e1 + e2 !== 0) $display("FAIL contention_excl: got %0d want 0", e1 + e2); else passed++;
  endtask

  task automatic test_fairness();
    int o, g, d, dow, r, c, e, esum;
    logic [7:0] b;
    esum = 0;
    data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_frame(1'b0, o, g, d, dow, b, r, c, e);
      esum += e;
      checks++;
      if (o !== (k % 2) || dow !== (k % 2))
        $display("FAIL fairness_frame%0d: got gnt %0d done %0d want %0d", k, o, dow, k % 2);
      else passed++;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (esum !== 0) $display("FAIL fairness_excl: got %0d want 0", esum); else passed++;
  endtask

  task automatic test_single();
    int o, g, d, dow, r, c, e;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    data0 = 8'hA5; req0 = 1'b1;
    wait_frame(1'b1, o, g, d, dow, b, r, c, e);
    checks++; if (o !== 0 || dow !== 0) $display("FAIL single_owner: got gnt %0d done %0d want 0", o, dow); else passed++;
    checks++; if (b !== 8'hA5) $display("FAIL single_bits: got %h want a5", b); else passed++;
    checks++; if (r !== 8) $display("FAIL single_rises: got %0d want 8", r); else passed++;
    checks++; if (d - g !== 64) $display("FAIL single_latency: got %0d want 64", d - g); else passed++;
    checks++; if (c !== 64) $display("FAIL single_cs_low: got %0d want 64", c); else passed++;
    checks++; if (busy !== 1'b1 || cs_n !== 1'b1) $display("FAIL single_done_state: got %b%b want 11", busy, cs_n); else passed++;
    @(negedge clk);
    checks++; if ({busy, done0} !== 2'b00) $display("FAIL single_idle: got %b want 00", {busy, done0}); else passed++;
  endtask

  task automatic test_late_request();
    int o1, g1, d1, do1, r1, c1, e1, o2, g2, d2, do2, r2, c2, e2;
    logic [7:0] b1, b2;
    repeat (3) @(negedge clk);
    data0 = 8'h96; req0 = 1'b1;
    fork
      wait_frame(1'b1, o1, g1, d1, do1, b1, r1, c1, e1);
      begin
        repeat (10) @(negedge clk);
        req1 = 1'b1;
        repeat (20) begin
          @(negedge clk);
          data1 = 8'($urandom);
        end
        data1 = 8'h3C;
      end
    join
    wait_frame(1'b1, o2, g2, d2, do2, b2, r2, c2, e2);
    checks++; if (o1 !== 0) $display("FAIL late_first: got %0d want 0", o1); else passed++;
    checks++; if (b1 !== 8'h96) $display("FAIL late_bits0: got %h want 96", b1); else passed++;
    checks++; if (e1 !== 0) $display("FAIL late_preempt: got %0d want 0", e1); else passed++;
    checks++; if (o2 !== 1 || g2 - d1 !== 2) $display("FAIL late_grant: got owner %0d gap %0d want 1 2", o2, g2 - d1); else passed++;
    checks++; if (b2 !== 8'h3C) $display("FAIL late_bits1: got %h want 3c", b2); else passed++;
  endtask

  task automatic test_reset_midframe();
    int o, g, d, dow, r, c, e, rises, seen_done;
    logic prev;
    logic [7:0] b;
    bit got;
    repeat (3) @(negedge clk);
    data0 = 8'hFF; req0 = 1'b1;
    got = 1'b0; rises = 0; seen_done = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = gnt0;
    end
    req0 = 1'b0;
    prev = sclk;
    for (int i = 0; i < 100 && rises < 3; i++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    checks++; if (rises !== 3 || sclk !== 1'b1) $display("FAIL midframe_reach: got %0d rises want 3"
      , rises); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({cs_n, sclk, busy} !== 3'b100) $display("FAIL midframe_abort: got %b want 100", {cs_n, sclk, busy}); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) seen_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) seen_done++;
    end
    checks++; if (seen_done !== 0) $display("FAIL midframe_no_done: got %0d want 0", seen_done); else passed++;
    data1 = 8'h5A; req1 = 1'b1;
    wait_frame(1'b1, o, g, d, dow, b, r, c, e);
    checks++; if (o !== 1 || dow !== 1) $display("FAIL midframe_next_owner: got %0d %0d want 1", o, dow); else passed++;
    checks++; if (b !== 8'h5A || d - g !== 64) $display("FAIL midframe_next_frame: got %h %0d want 5a 64", b, d - g); else passed++;
  endtask

  task automatic test_divider();
    int g, d, toggles;
    logic prev;
    logic [3:0] b;
    bit got, fin;
    got = 1'b0; fin = 1'b0; toggles = 0; b = '0; g = 0; d = 0;
    ddata1 = 4'hC; dreq1 = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dgnt1;
    end
    g = cyc;
    dreq1 = 1'b0;
    prev = dsclk;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (dsclk !== prev) toggles++;
      if (dsclk && !prev) b = {b[2:0], dsdata};
      prev = dsclk;
      fin = ddone1;
    end
    d = cyc;
    checks++; if (!got) $display("FAIL div_grant: got 0 want 1"); else passed++;
    checks++; if (d - g !== 8) $display("FAIL div_latency: got %0d want 8", d - g); else passed++;
    checks++; if (toggles !== 8) $display("FAIL div_toggles: got %0d want 8", toggles); else passed++;
    checks++; if (b !== 4'hC) $display("FAIL div_bits: got %h want c", b); else passed++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_single();
    test_late_request();
    test_reset_midframe();
    test_divider();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
